// File: rtl/dma_pkt_writer.sv
// Per-PE DMA write engine: pops complete packets from the dispatcher FIFOs
// and writes each one into the next free slot of a memory ring.
module dma_pkt_writer #(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_BYTES = 2048
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_pkt_fifo_empty,
  input  logic [133:0]                 i_pkt_fifo_dout,
  output logic                         o_pkt_fifo_rden,
  input  logic                         i_len_fifo_empty,
  input  logic [15:0]                  i_len_fifo_dout,
  output logic                         o_len_fifo_rden,
  input  logic [31:0]                  i_buf_base,
  output logic                         o_mem_wren,
  output logic [31:0]                  o_mem_addr,
  output logic [127:0]                 o_mem_wdata,
  output logic [15:0]                  o_mem_wstrb,
  input  logic                         i_slot_release,
  output logic                         o_done,
  output logic [$clog2(NUM_SLOTS)-1:0] o_done_slot,
  output logic [15:0]                  o_done_len,
  output logic [$clog2(NUM_SLOTS):0]   o_free_cnt,
  output logic [15:0]                  o_drop_cnt
);

  localparam int SLOT_W     = $clog2(NUM_SLOTS);
  localparam int BEATS      = SLOT_BYTES / 16;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOT_SHIFT = $clog2(SLOT_BYTES);
  localparam logic [SLOT_W:0]   FREE_MAX     = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BEATS - 1);
  localparam logic [16:0]       SLOT_BYTES_L = 17'(SLOT_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WRITE = 3'd2,
    DROP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [15:0]         len_r;
  logic [SLOT_W-1:0]   wr_slot_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [SLOT_W:0]     free_cnt_r;
  logic [15:0]         drop_cnt_r;
  logic                mem_wren_r;
  logic [31:0]         mem_addr_r;
  logic [127:0]        mem_wdata_r;
  logic [15:0]         mem_wstrb_r;
  logic                done_r;
  logic [SLOT_W-1:0]   done_slot_r;
  logic [15:0]         done_len_r;

  logic                pkt_pop_s;
  logic                len_pop_s;
  logic                is_tail_s;
  logic [3:0]          tail_v_s;
  logic [15:0]         tail_strb_s;
  logic [15:0]         wstrb_s;
  logic [31:0]         addr_s;
  logic                consume_s;
  logic                unused_base_s;

  // The cycle after o_done is held off so o_done_slot is seen before the next length pop.
  assign len_pop_s = (state_r == IDLE) && !i_len_fifo_empty && !done_r;
  assign pkt_pop_s = ((state_r == WRITE) || (state_r == DROP)) && !i_pkt_fifo_empty;
  assign is_tail_s = (i_pkt_fifo_dout[133:132] == 2'b10);
  assign tail_v_s  = i_pkt_fifo_dout[131:128];
  assign wstrb_s   = is_tail_s ? tail_strb_s : 16'hFFFF;
  assign consume_s = (state_r == DONE);
  assign addr_s    = {i_buf_base[31:4], 4'h0}
                   + (32'(wr_slot_r) << SLOT_SHIFT)
                   + (32'(beat_cnt_r) << 4);
  assign unused_base_s = ^i_buf_base[3:0];

  assign o_pkt_fifo_rden = pkt_pop_s;
  assign o_len_fifo_rden = len_pop_s;
  assign o_mem_wren      = mem_wren_r;
  assign o_mem_addr      = mem_addr_r;
  assign o_mem_wdata     = mem_wdata_r;
  assign o_mem_wstrb     = mem_wstrb_r;
  assign o_done          = done_r;
  assign o_done_slot     = done_slot_r;
  assign o_done_len      = done_len_r;
  assign o_free_cnt      = free_cnt_r;
  assign o_drop_cnt      = drop_cnt_r;

  // Tail byte enables: v valid bytes from the top lane down, v=0 meaning a full word.
  always_comb begin
    tail_strb_s = 16'hFFFF;
    if (tail_v_s == 4'd0) begin
      tail_strb_s = 16'hFFFF;
    end else begin
      tail_strb_s = 16'hFFFF << (5'd16 - {1'b0, tail_v_s});
    end
  end

  // Free-slot accounting: a release and a consume in the same cycle cancel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      free_cnt_r <= FREE_MAX;
    end else if (consume_s && i_slot_release) begin
      free_cnt_r <= free_cnt_r;
    end else if (consume_s) begin
      free_cnt_r <= free_cnt_r - (SLOT_W + 1)'(1'b1);
    end else if (i_slot_release && (free_cnt_r < FREE_MAX)) begin
      free_cnt_r <= free_cnt_r + (SLOT_W + 1)'(1'b1);
    end
  end

  // Packet FSM with registered memory-write and completion outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= IDLE;
      len_r       <= 16'd0;
      wr_slot_r   <= {SLOT_W{1'b0}};
      beat_cnt_r  <= {BEAT_W{1'b0}};
      drop_cnt_r  <= 16'd0;
      mem_wren_r  <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 128'd0;
      mem_wstrb_r <= 16'd0;
      done_r      <= 1'b0;
      done_slot_r <= {SLOT_W{1'b0}};
      done_len_r  <= 16'd0;
    end else begin
      mem_wren_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (len_pop_s) begin
            len_r   <= i_len_fifo_dout;
            state_r <= CHECK;
          end
        end
        CHECK: begin
          beat_cnt_r <= {BEAT_W{1'b0}};
          if ((free_cnt_r == {(SLOT_W + 1){1'b0}}) || (len_r == 16'd0) ||
              ({1'b0, len_r} > SLOT_BYTES_L)) begin
            state_r <= DROP;
          end else begin
            state_r <= WRITE;
          end
        end
        WRITE: begin
          if (pkt_pop_s) begin
            // A body word on the last beat would spill into the next slot.
            if (is_tail_s || (beat_cnt_r != LAST_BEAT)) begin
              mem_wren_r  <= 1'b1;
              mem_addr_r  <= addr_s;
              mem_wdata_r <= i_pkt_fifo_dout[127:0];
              mem_wstrb_r <= wstrb_s;
              beat_cnt_r  <= beat_cnt_r + BEAT_W'(1'b1);
            end
            if (is_tail_s) begin
              state_r <= DONE;
            end else if (beat_cnt_r == LAST_BEAT) begin
              state_r <= DROP;
            end
          end
        end
        DROP: begin
          if (pkt_pop_s && is_tail_s) begin
            if (drop_cnt_r != 16'hFFFF) begin
              drop_cnt_r <= drop_cnt_r + 16'd1;
            end
            state_r <= IDLE;
          end
        end
        DONE: begin
          done_r      <= 1'b1;
          done_slot_r <= wr_slot_r;
          done_len_r  <= len_r;
          wr_slot_r   <= wr_slot_r + SLOT_W'(1'b1);
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_pkt_writer.sv
// Scoreboard bench for dma_pkt_writer: FIFO model feeds directed packets,
// a negedge monitor checks every memory write and done pulse against queues.
module tb_dma_pkt_writer;

  localparam int NS = 8;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_pkt_fifo_empty;
  logic [133:0] i_pkt_fifo_dout;
  logic         o_pkt_fifo_rden;
  logic         i_len_fifo_empty;
  logic [15:0]  i_len_fifo_dout;
  logic         o_len_fifo_rden;
  logic [31:0]  i_buf_base;
  logic         o_mem_wren;
  logic [31:0]  o_mem_addr;
  logic [127:0] o_mem_wdata;
  logic [15:0]  o_mem_wstrb;
  logic         i_slot_release;
  logic         o_done;
  logic [2:0]   o_done_slot;
  logic [15:0]  o_done_len;
  logic [3:0]   o_free_cnt;
  logic [15:0]  o_drop_cnt;

  dma_pkt_writer #(.NUM_SLOTS(8), .SLOT_BYTES(2048)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pkt_fifo_empty(i_pkt_fifo_empty), .i_pkt_fifo_dout(i_pkt_fifo_dout),
    .o_pkt_fifo_rden(o_pkt_fifo_rden),
    .i_len_fifo_empty(i_len_fifo_empty), .i_len_fifo_dout(i_len_fifo_dout),
    .o_len_fifo_rden(o_len_fifo_rden),
    .i_buf_base(i_buf_base),
    .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_slot_release(i_slot_release),
    .o_done(o_done), .o_done_slot(o_done_slot), .o_done_len(o_done_len),
    .o_free_cnt(o_free_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } wr_t;

  logic [133:0] pq[$];
  logic [15:0]  lq[$];
  wr_t          exp_wr[$];
  logic [18:0]  exp_done[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   len_pop_cyc = 0;
  int   done_cyc = 0;
  int   m_slot, m_free, m_drop, pkt_id;
  logic gap_en = 1'b0;
  logic tog = 1'b0;
  logic fifo_pk, fifo_lk;
  wr_t  mon_e;
  logic [18:0] mon_d;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Show-ahead FIFO model: pops what the DUT sampled, then presents the new head.
  always @(posedge i_clk) begin
    fifo_pk = o_pkt_fifo_rden;
    fifo_lk = o_len_fifo_rden;
    #1;
    if (i_rst) begin
      pq.delete();
      lq.delete();
    end else begin
      if (fifo_pk && pq.size() > 0) void'(pq.pop_front());
      if (fifo_lk && lq.size() > 0) void'(lq.pop_front());
    end
    tog = ~tog;
    i_pkt_fifo_empty = (pq.size() == 0) || (gap_en && tog);
    i_pkt_fifo_dout  = (pq.size() > 0) ? pq[0] : 134'd0;
    i_len_fifo_empty = (lq.size() == 0);
    i_len_fifo_dout  = (lq.size() > 0) ? lq[0] : 16'd0;
  end

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_len_fifo_rden) len_pop_cyc = cyc;
      if (o_mem_wren) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h required=none", o_mem_addr);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("mem_write", {o_mem_addr, o_mem_wdata, o_mem_wstrb}, mon_e);
        end
      end
      if (o_done) begin
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%0h required=none", {o_done_slot, o_done_len});
        end else begin
          mon_d = exp_done.pop_front();
          chk("done", {o_done_slot, o_done_len}, mon_d);
        end
      end
    end
  end

  task automatic send_pkt(input int len, input int nwords, input int n_exp_wr, input bit exp_ok);
    logic [3:0]   v;
    logic [1:0]   fl;
    logic [127:0] d;
    logic [31:0]  ab;
    logic [15:0]  st;
    int           nb;
    v  = 4'(len % 16);
    ab = {i_buf_base[31:4], 4'h0} + 32'(m_slot) * 32'd2048;
    for (int i = 0; i < nwords; i++) begin
      fl = (i == 0) ? 2'b11 : ((i == nwords - 1) ? 2'b10 : 2'b00);
      d  = {32'(pkt_id), 32'(i), ~32'(pkt_id), 32'h5A5A_0000 ^ 32'(i)};
      pq.push_back({fl, (i == nwords - 1) ? v : 4'h0, d});
      nb = (i == nwords - 1 && v != 4'h0) ? int'(v) : 16;
      st = 16'h0000;
      for (int b = 0; b < nb; b++) st[15 - b] = 1'b1;
      if (i < n_exp_wr) exp_wr.push_back({ab + 32'(i) * 32'd16, d, st});
    end
    lq.push_back(16'(len));
    if (exp_ok) begin
      exp_done.push_back({3'(m_slot), 16'(len)});
      m_slot = (m_slot + 1) % NS;
      m_free--;
    end
    pkt_id++;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      if (pq.size() == 0 && lq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", pq.size());
    end
    repeat (8) @(negedge i_clk);
  endtask

  task automatic wait_len_pop();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (o_len_fifo_rden) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL len_pop_timeout actual=0 required=1");
    end
  endtask

  task automatic release_slot();
    @(negedge i_clk);
    i_slot_release = 1'b1;
    @(negedge i_clk);
    i_slot_release = 1'b0;
    if (m_free < NS) m_free++;
  endtask

  task automatic model_reset();
    m_slot = 0;
    m_free = NS;
    m_drop = 0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_slot_release = 1'b0;
    i_pkt_fifo_empty = 1'b1;
    i_pkt_fifo_dout = 134'd0;
    i_len_fifo_empty = 1'b1;
    i_len_fifo_dout = 16'd0;
    i_buf_base = 32'h1000_0000;
    pkt_id = 1;
    model_reset();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset_outputs", {o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_done, o_done_slot,
                          o_done_len, o_drop_cnt, o_pkt_fifo_rden, o_len_fifo_rden}, 256'd0);
    chk("reset_free", o_free_cnt, 256'd8);

    // 60-byte packet: 4 writes, last strobe FFF0, done 7 cycles after length pop.
    send_pkt(60, 4, 4, 1'b1);
    drain();
    chk("t1_done_latency", done_cyc - len_pop_cyc, 256'd7);
    chk("t1_free", o_free_cnt, 256'd7);

    // Fresh ring, 9 packets with no releases: 8 written, 9th dropped.
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    for (int k = 0; k < 9; k++) send_pkt(64, 4, (k < 8) ? 4 : 0, k < 8);
    m_drop++;
    drain();
    chk("t2_drop", o_drop_cnt, 256'(m_drop));
    chk("t2_free", o_free_cnt, 256'd0);

    // Release one slot, then wrap into slot 0 with a release coincident with the consume.
    release_slot();
    chk("t3_free_after_release", o_free_cnt, 256'd1);
    send_pkt(48, 3, 3, 1'b1);
    wait_len_pop();
    repeat (5) @(negedge i_clk);
    i_slot_release = 1'b1;
    @(negedge i_clk);
    i_slot_release = 1'b0;
    m_free++;
    chk("t3_done_now", o_done, 256'd1);
    chk("t3_free_same_cycle", o_free_cnt, 256'(m_free));
    drain();
    chk("t3_free_after", o_free_cnt, 256'(m_free));

    // Oversize length and overflowing word count are both dropped.
    send_pkt(2049, 129, 0, 1'b0);
    m_drop++;
    drain();
    chk("t4_drop_len", o_drop_cnt, 256'(m_drop));
    send_pkt(1024, 129, 127, 1'b0);
    m_drop++;
    drain();
    chk("t4_drop_overflow", o_drop_cnt, 256'(m_drop));
    chk("t4_free", o_free_cnt, 256'(m_free));

    // Gappy packet FIFO, unaligned base (low bits ignored).
    i_buf_base = 32'h2000_0008;
    gap_en = 1'b1;
    send_pkt(100, 7, 7, 1'b1);
    drain();
    gap_en = 1'b0;
    chk("t5_free", o_free_cnt, 256'd0);
    for (int k = 0; k < 9; k++) release_slot();
    chk("t5_free_saturate", o_free_cnt, 256'(m_free));

    // Reset during beat 3 of a 10-word packet.
    send_pkt(160, 10, 3, 1'b0);
    wait_len_pop();
    repeat (5) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("t6_reset_outputs", {o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_wstrb, o_done, o_done_slot,
                             o_done_len, o_drop_cnt}, 256'd0);
    chk("t6_reset_free", o_free_cnt, 256'd8);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    send_pkt(32, 2, 2, 1'b1);
    drain();
    chk("t6_free_after", o_free_cnt, 256'(m_free));

    chk("writes_left", exp_wr.size(), 256'd0);
    chk("dones_left", exp_done.size(), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_pkt_writer.md
# dma_pkt_writer

Per-PE DMA write engine placed directly downstream of the packet dispatcher, one instance per PE. It consumes complete packets from that PE's show-ahead packet FIFO (134-bit words) and length FIFO (16-bit entries). Each packet is written into a ring of fixed-size slots in the PE's data memory through a 128-bit write port. On completion the block posts a done pulse with slot index and length; the block drops packets when no slot is free or the packet is malformed.

## Interface
- NUM_SLOTS, 8, number of ring slots (power of 2, ≥2).
- SLOT_BYTES, 2048, bytes per slot (power of 2, multiple of 16).
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_pkt_fifo_empty  in  1  packet FIFO empty.
- i_pkt_fifo_dout  in  134  show-ahead word; [133:132] flag (11 head, 00 body, 10 tail); [131:128] valid bytes in tail word, 0 means 16; [127:0] data, byte 0 at [127:120].
- o_pkt_fifo_rden  out  1  pop packet FIFO.
- i_len_fifo_empty  in  1  length FIFO empty.
- i_len_fifo_dout  in  16  packet length in bytes.
- o_len_fifo_rden  out  1  pop length FIFO.
- i_buf_base  in  32  ring base byte address; bits [3:0] ignored.
- o_mem_wren  out  1  memory write strobe.
- o_mem_addr  out  32  byte address, 16-byte aligned.
- o_mem_wdata  out  128  write data.
- o_mem_wstrb  out  16  byte enables; bit 15 = bits [127:120].
- i_slot_release  in  1  software frees one slot (pulse).
- o_done  out  1  packet-written pulse.
- o_done_slot  out  $clog2(NUM_SLOTS)  slot of completed packet.
- o_done_len  out  16  length of completed packet.
- o_free_cnt  out  $clog2(NUM_SLOTS)+1  free slots.
- o_drop_cnt  out  16  dropped packets, saturating at 16'hFFFF.

## Operation
- States: IDLE, CHECK, WRITE, DROP, DONE.
- IDLE: when !i_len_fifo_empty, pulse o_len_fifo_rden for 1 cycle, latch the length into len_r, then go to CHECK. The dispatcher writes a length only after the packet tail, so a complete packet is already in the packet FIFO.
- CHECK: go to DROP if free_cnt==0, len_r==0, or len_r>SLOT_BYTES. Otherwise clear beat_cnt and go to WRITE.
- WRITE: o_pkt_fifo_rden = !i_pkt_fifo_empty (combinational). For each popped word, the next cycle drives:
  - o_mem_wren=1.
  - o_mem_addr = {i_buf_base[31:4],4'b0} + wr_slot*SLOT_BYTES + beat_cnt*16 (32-bit, wraps mod 2^32).
  - o_mem_wdata = dout[127:0].
  - o_mem_wstrb = 16'hFFFF, except on tail: 16'hFFFF << (16-v), where v = dout[131:128] and v=0 means 16.
  - beat_cnt increments after each popped word.
- Tail popped in WRITE: go to DONE.
- Overflow: a non-tail word popped when beat_cnt == SLOT_BYTES/16-1 has its write suppressed. The block goes to DROP and continues popping through the tail.
- DROP: pop words with no memory writes until a tail is popped. Then o_drop_cnt increments (saturating) and the block returns to IDLE. No o_done is produced.
- DONE: registered 1-cycle pulse of o_done with o_done_slot=wr_slot and o_done_len=len_r. In the same cycle wr_slot increments mod NUM_SLOTS and free_cnt decrements. Next state is IDLE.
- free_cnt:
  - Resets to NUM_SLOTS.
  - i_slot_release increments it.
  - Release and consume in the same cycle leave it unchanged.
  - A release while free_cnt==NUM_SLOTS is ignored.
- Flag fields are trusted. A head flag is not re-checked.

## Timing
- Reset values:
  - o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0, o_mem_wstrb=0.
  - o_done=0, o_done_slot=0, o_done_len=0.
  - o_drop_cnt=0, o_free_cnt=NUM_SLOTS.
  - State IDLE, wr_slot=0.
  - The rden outputs are 0 because they decode from IDLE.
- Reset asserted mid-packet aborts the packet immediately. The FIFOs are reset by the same i_rst.
- Length pop at cycle t, CHECK at t+1, first packet pop at t+2 (if not empty).
- With no empty gaps in the packet FIFO, an N-word packet's writes occupy t+3..t+2+N. o_done is at t+3+N, and the next length pop is no earlier than t+4+N.
- An empty packet FIFO in WRITE or DROP stalls with no write. Address and beat_cnt hold.
- All outputs except the rden signals are registered.

## Test plan
- Base 0x1000_0000, one 60-byte packet (head, 2 body, tail v=12): 4 writes at 0x1000_0000..0x1000_0030. Last wstrb is 16'hFFF0. o_done at t+7 with slot 0, len 60, then free_cnt=7.
- 9 packets of 64 bytes, no releases: first 8 land in slots 0..7. The 9th is drained with no writes, o_drop_cnt=1, free_cnt=0.
- One release, then another packet: the packet is written to slot 0 (wrap). Release and o_done in the same cycle: free_cnt unchanged.
- Length 2049, and separately length 1024 with 129 words: no write beyond slot end (≤128 writes). Both are dropped and o_drop_cnt increments by 1 for each packet.
- Packet FIFO toggling empty every other cycle mid-packet: addresses stay contiguous with no duplicate or missed beats.
- Assert i_rst during beat 3 of a 10-word packet: all outputs return to reset values within the cycle, and the next packet after reset goes to slot 0.
